// File: rtl/command_decoder_v2.sv
// Byte-stream command decoder: opcode + 0..6 LE arg bytes -> one-cycle mode/pixel strobe or error pulse.
// Latency: last arg at N -> strobe at N+2; backpressure: holds in ISSUE (o_rdy=0) until i_gen_ready.
module command_decoder_v2 #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 12,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_we,
    input  logic               i_en,
    input  logic [7:0]         i_data,
    output logic               o_ack,
    output logic               o_rdy,
    input  logic               i_gen_ready,
    output logic [7:0]         o_mode,
    output logic               o_set_mode,
    output logic [COORD_W-1:0] o_pixel_x,
    output logic [COORD_W-1:0] o_pixel_y,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_set_pixel,
    output logic               o_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARGS  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SET_MODE  = 2'd1;
    localparam logic [1:0] OP_SET_BG    = 2'd2;
    localparam logic [1:0] OP_SET_PIXEL = 2'd3;

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [47:0]        args_q, args_d;
    logic [2:0]         argcnt_q, argcnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               set_mode_q, set_mode_d;
    logic               set_pixel_q, set_pixel_d;
    logic [7:0]         mode_q, mode_d;
    logic [COORD_W-1:0] pixel_x_q, pixel_x_d;
    logic [COORD_W-1:0] pixel_y_q, pixel_y_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic               accept;
    logic [2:0]         last_idx;
    logic               unused_args_bits;

    assign o_rdy  = (state_q != ST_ISSUE);
    assign accept = i_we && i_en && o_rdy;

    // Index of the final arg byte for the latched opcode.
    always_comb begin
        last_idx = 3'd0;
        case (op_q)
            OP_SET_MODE:  last_idx = 3'd0;
            OP_SET_BG:    last_idx = 3'd1;
            OP_SET_PIXEL: last_idx = 3'd5;
            default:      last_idx = 3'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        args_d      = args_q;
        argcnt_d    = argcnt_q;
        tmo_d       = tmo_q;
        ack_d       = accept;
        err_d       = 1'b0;
        set_mode_d  = 1'b0;
        set_pixel_d = 1'b0;
        mode_d      = mode_q;
        pixel_x_d   = pixel_x_q;
        pixel_y_d   = pixel_y_q;
        color_d     = color_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (i_data == 8'd0) begin
                        state_d = ST_IDLE;
                    end else if (i_data > 8'd3) begin
                        err_d = 1'b1;
                    end else begin
                        op_d     = i_data[1:0];
                        args_d   = '0;
                        argcnt_d = 3'd0;
                        tmo_d    = '0;
                        state_d  = ST_ARGS;
                    end
                end
            end

            ST_ARGS: begin
                if (accept) begin
                    args_d[{argcnt_q, 3'b000} +: 8] = i_data;
                    argcnt_d = argcnt_q + 3'd1;
                    tmo_d    = '0;
                    if (argcnt_q == last_idx) begin
                        state_d = ST_ISSUE;
                    end
                end else if (TIMEOUT != 0) begin
                    // Host stalled mid-command: drop the partial command entirely.
                    if (tmo_q == TMO_LAST) begin
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                        args_d   = '0;
                        argcnt_d = 3'd0;
                        tmo_d    = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
            end

            ST_ISSUE: begin
                if (i_gen_ready) begin
                    state_d  = ST_IDLE;
                    argcnt_d = 3'd0;
                    case (op_q)
                        OP_SET_MODE: begin
                            mode_d     = args_q[7:0];
                            set_mode_d = 1'b1;
                        end
                        OP_SET_BG: begin
                            pixel_x_d   = '0;
                            pixel_y_d   = '0;
                            color_d     = args_q[COLOR_W-1:0];
                            set_pixel_d = 1'b1;
                        end
                        OP_SET_PIXEL: begin
                            pixel_x_d   = args_q[COORD_W-1:0];
                            pixel_y_d   = args_q[16 +: COORD_W];
                            color_d     = args_q[32 +: COLOR_W];
                            set_pixel_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            args_q      <= '0;
            argcnt_q    <= 3'd0;
            tmo_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            set_mode_q  <= 1'b0;
            set_pixel_q <= 1'b0;
            mode_q      <= 8'd0;
            pixel_x_q   <= '0;
            pixel_y_q   <= '0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            args_q      <= args_d;
            argcnt_q    <= argcnt_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            set_mode_q  <= set_mode_d;
            set_pixel_q <= set_pixel_d;
            mode_q      <= mode_d;
            pixel_x_q   <= pixel_x_d;
            pixel_y_q   <= pixel_y_d;
            color_q     <= color_d;
        end
    end

    // Upper bits of each 16-bit field are dropped when widths are narrower than 16.
    assign unused_args_bits = ^args_q;

    assign o_ack       = ack_q;
    assign o_error     = err_q;
    assign o_set_mode  = set_mode_q;
    assign o_set_pixel = set_pixel_q;
    assign o_mode      = mode_q;
    assign o_pixel_x   = pixel_x_q;
    assign o_pixel_y   = pixel_y_q;
    assign o_color     = color_q;

endmodule

// File: tb/tb_command_decoder_v2.sv
// Directed bench for command_decoder_v2 (TIMEOUT=4): pulse counts, outputs and latency per scenario.
module tb_command_decoder_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, en, gen_ready;
    logic [7:0]  data;
    logic        ack, rdy, set_mode, set_pixel, err;
    logic [7:0]  mode;
    logic [9:0]  px, py;
    logic [11:0] color;

    int total = 0;
    int bad   = 0;
    int n_ack = 0, n_mode = 0, n_pix = 0, n_err = 0, n_clash = 0;

    always #5 clk = ~clk;

    command_decoder_v2 #(.COORD_W(10), .COLOR_W(12), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_we(we), .i_en(en), .i_data(data),
        .o_ack(ack), .o_rdy(rdy), .i_gen_ready(gen_ready),
        .o_mode(mode), .o_set_mode(set_mode),
        .o_pixel_x(px), .o_pixel_y(py), .o_color(color),
        .o_set_pixel(set_pixel), .o_error(err)
    );

    // Pulse counters sampled mid-cycle; any overlap of strobes/error is a clash.
    always @(negedge clk) begin
        if (!rst) begin
            n_ack  += int'(ack);
            n_mode += int'(set_mode);
            n_pix  += int'(set_pixel);
            n_err  += int'(err);
            if ((set_mode && set_pixel) || (err && (set_mode || set_pixel)))
                n_clash++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_ack = 0; n_mode = 0; n_pix = 0; n_err = 0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one byte; returns 1ns after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        int waited = 0;
        while (!rdy && waited < 50) begin
            cycles(1);
            waited++;
        end
        check("rdy_wait", 32'(rdy), 32'd1);
        we = 1'b1; en = 1'b1; data = b;
        cycles(1);
        we = 1'b0; en = 1'b0; data = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; en = 1'b0; data = 8'h00; gen_ready = 1'b1;
        cycles(2);
        check("rst_rdy",   32'(rdy), 32'd1);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_mode",  32'(mode), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b0;
        cycles(2);

        // SET_MODE with exact latency
        clr_counts();
        send(8'h01);
        send(8'h05);
        check("mode_issue_rdy", 32'(rdy), 32'd0);
        check("mode_no_early",  32'(set_mode), 32'd0);
        cycles(1);
        check("mode_strobe_n2", 32'(set_mode), 32'd1);
        check("mode_val",       32'(mode), 32'h05);
        check("mode_rdy_back",  32'(rdy), 32'd1);
        cycles(3);
        check("mode_acks",  32'(n_ack), 32'd2);
        check("mode_nstb",  32'(n_mode), 32'd1);
        check("mode_npix",  32'(n_pix), 32'd0);

        // SET_PIXEL, excess upper bits dropped
        clr_counts();
        send(8'h03); send(8'h3F); send(8'h01); send(8'hE0);
        send(8'h01); send(8'hAB); send(8'h0F);
        cycles(3);
        check("pix_x",     32'(px), 32'h13F);
        check("pix_y",     32'(py), 32'h1E0);
        check("pix_color", 32'(color), 32'hFAB);
        check("pix_nstb",  32'(n_pix), 32'd1);
        check("pix_acks",  32'(n_ack), 32'd7);
        check("pix_mode_hold", 32'(mode), 32'h05);

        // SET_BG_COLOR under backpressure, with a byte offered during the hold
        clr_counts();
        gen_ready = 1'b0;
        send(8'h02); send(8'h34); send(8'h12);
        we = 1'b1; en = 1'b1; data = 8'h55;
        cycles(10);
        we = 1'b0; en = 1'b0; data = 8'h00;
        check("bp_rdy",   32'(rdy), 32'd0);
        check("bp_acks",  32'(n_ack), 32'd3);
        check("bp_nstb",  32'(n_pix), 32'd0);
        check("bp_hold_x", 32'(px), 32'h13F);
        gen_ready = 1'b1;
        cycles(3);
        check("bg_color", 32'(color), 32'h234);
        check("bg_x",     32'(px), 32'd0);
        check("bg_y",     32'(py), 32'd0);
        check("bg_nstb",  32'(n_pix), 32'd1);
        check("bg_acks",  32'(n_ack), 32'd3);

        // Illegal opcode, NOOP, then a normal command
        clr_counts();
        send(8'h7F);
        cycles(2);
        check("ill_err",  32'(n_err), 32'd1);
        check("ill_ack",  32'(n_ack), 32'd1);
        send(8'h00);
        cycles(2);
        check("noop_ack", 32'(n_ack), 32'd2);
        check("noop_err", 32'(n_err), 32'd1);
        check("noop_stb", 32'(n_mode + n_pix), 32'd0);
        send(8'h01); send(8'h02);
        cycles(3);
        check("after_ill_mode", 32'(mode), 32'h02);
        check("after_ill_nstb", 32'(n_mode), 32'd1);

        // Arg timeout: error only after the fourth idle cycle
        clr_counts();
        send(8'h03); send(8'h10);
        cycles(3);
        check("tmo_not_yet", 32'(n_err), 32'd0);
        cycles(3);
        check("tmo_err",  32'(n_err), 32'd1);
        check("tmo_rdy",  32'(rdy), 32'd1);
        send(8'h01); send(8'h07);
        cycles(3);
        check("tmo_next_mode", 32'(mode), 32'h07);
        check("tmo_nstb",  32'(n_mode), 32'd1);
        check("tmo_npix",  32'(n_pix), 32'd0);

        // Async reset mid-command
        clr_counts();
        send(8'h03); send(8'h11); send(8'h22);
        rst = 1'b1;
        cycles(2);
        check("mrst_mode",  32'(mode), 32'd0);
        check("mrst_color", 32'(color), 32'd0);
        check("mrst_rdy",   32'(rdy), 32'd1);
        rst = 1'b0;
        cycles(8);
        check("mrst_nstb", 32'(n_mode + n_pix), 32'd0);
        check("mrst_nerr", 32'(n_err), 32'd0);
        send(8'h01); send(8'h09);
        cycles(3);
        check("mrst_mode9", 32'(mode), 32'h09);
        check("mrst_nmode", 32'(n_mode), 32'd1);

        check("no_clash", 32'(n_clash), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
